// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: streams the signed digits of a latched multiplier operand.
// Define BOOTH_ZERO_SKIP_EN to suppress value-zero digits (true positions kept on dig_idx).
module booth_digit_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_x,
  output logic                          dig_valid,
  input  logic                          dig_ready,
  output logic [2:0]                    dig_sdn,
  output logic [$clog2(WIDTH/2)-1:0]    dig_idx,
  output logic                          dig_last
);

  localparam int N  = WIDTH / 2;
  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t          state_reg, state_next;
  // Operand stored with the implicit x[-1] = 0 appended as bit 0.
  logic [WIDTH:0]  x_reg, x_next;
  logic [IW-1:0]   idx_reg, idx_next;

  logic [2:0]      cur_sdn;
  logic            cur_last;
  logic [IW-1:0]   next_idx;
  logic [IW-1:0]   first_idx;

  function automatic logic [2:0] encode(input logic [2:0] t);
    logic [2:0] s;
    case (t)
      3'b001, 3'b010: s = 3'b010;
      3'b011:         s = 3'b100;
      3'b100:         s = 3'b101;
      3'b101, 3'b110: s = 3'b011;
      default:        s = 3'b000;
    endcase
    return s;
  endfunction

  assign cur_sdn = encode(x_reg[{idx_reg, 1'b0} +: 3]);

`ifdef BOOTH_ZERO_SKIP_EN
  logic [WIDTH:0] in_ext;
  logic [N-1:0]   nz_cur;
  logic [N-1:0]   nz_in;

  assign in_ext = {in_x, 1'b0};

  // A digit is zero exactly when its three triplet bits are equal.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_nz
      assign nz_cur[gi] = !((x_reg[2*gi+2] == x_reg[2*gi+1]) && (x_reg[2*gi+1] == x_reg[2*gi]));
      assign nz_in[gi]  = !((in_ext[2*gi+2] == in_ext[2*gi+1]) && (in_ext[2*gi+1] == in_ext[2*gi]));
    end
  endgenerate

  // Lowest nonzero digit above the current one; none left means this is the last.
  always_comb begin
    cur_last  = 1'b1;
    next_idx  = idx_reg;
    first_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if ((j > int'(idx_reg)) && nz_cur[j]) begin
        cur_last = 1'b0;
        next_idx = IW'(j);
      end
      if (nz_in[j]) begin
        first_idx = IW'(j);
      end
    end
  end
`else
  always_comb begin
    cur_last  = (idx_reg == IW'(N - 1));
    next_idx  = idx_reg + IW'(1);
    first_idx = '0;
  end
`endif

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          x_next     = {in_x, 1'b0};
          idx_next   = first_idx;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (dig_ready) begin
          if (cur_last) begin
            state_next = IDLE;
          end else begin
            idx_next = next_idx;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      idx_reg   <= idx_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign dig_valid = (state_reg == EMIT);
  assign dig_sdn   = dig_valid ? cur_sdn  : 3'b000;
  assign dig_idx   = dig_valid ? idx_reg  : '0;
  assign dig_last  = dig_valid ? cur_last : 1'b0;

endmodule

// File: tb/tb_booth_digit_encoder.sv
// Randomized self-checking bench for booth_digit_encoder (WIDTH = 8), reference model
// built from digit values x[2i-1] + x[2i] - 2*x[2i+1]; honours BOOTH_ZERO_SKIP_EN.
module tb_booth_digit_encoder;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic       dig_valid;
  logic       dig_ready;
  logic [2:0] dig_sdn;
  logic [1:0] dig_idx;
  logic       dig_last;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_sdn[$];
  int         exp_idx[$];

  booth_digit_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_sdn   (dig_sdn),
    .dig_idx   (dig_idx),
    .dig_last  (dig_last)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] sdn_of(input int v);
    case (v)
      1:       return 3'b010;
      2:       return 3'b100;
      -1:      return 3'b011;
      -2:      return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Expected digit stream from the arithmetic digit definition.
  task automatic build_expected(input logic [7:0] x);
    logic [8:0] ext;
    int d;
    ext = {x, 1'b0};
    exp_sdn.delete();
    exp_idx.delete();
    for (int i = 0; i < N; i++) begin
      d = int'(ext[2*i]) + int'(ext[2*i+1]) - 2 * int'(ext[2*i+2]);
`ifdef BOOTH_ZERO_SKIP_EN
      if (d != 0) begin
        exp_sdn.push_back(sdn_of(d));
        exp_idx.push_back(i);
      end
`else
      exp_sdn.push_back(sdn_of(d));
      exp_idx.push_back(i);
`endif
    end
    if (exp_sdn.size() == 0) begin
      exp_sdn.push_back(3'b000);
      exp_idx.push_back(0);
    end
  endtask

  // stall_mode: 0 = always ready, 1 = random ready, 2 = three stall cycles at the second digit
  task automatic run_operand(input logic [7:0] x, input int stall_mode, input logic signed [7:0] y);
    int n, k, cycles, stalls, acc, pp, expv;
    logic rdy;
    build_expected(x);
    n = exp_sdn.size();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready x=%02h got=%b want=1", x, in_ready);
    end
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = 8'($urandom);
    k = 0; cycles = 0; stalls = 0; acc = 0;
    while (k < n && cycles < 100) begin
      cycles++;
      checks++;
      if (dig_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL digit_valid x=%02h k=%0d got valid=%b ready=%b want valid=1 ready=0",
                 x, k, dig_valid, in_ready);
        break;
      end
      checks++;
      if (dig_sdn !== exp_sdn[k] || int'(dig_idx) != exp_idx[k] || dig_last !== (k == n - 1)) begin
        failures++;
        $display("FAIL digit x=%02h k=%0d got sdn=%b idx=%0d last=%b want sdn=%b idx=%0d last=%b",
                 x, k, dig_sdn, dig_idx, dig_last, exp_sdn[k], exp_idx[k], (k == n - 1));
      end
      if (stall_mode == 0) rdy = 1'b1;
      else if (stall_mode == 1) rdy = 1'($urandom_range(0, 1));
      else rdy = !(k == 1 && stalls < 3);
      if (!rdy) stalls++;
      dig_ready = rdy;
      if (rdy) begin
        pp = dig_sdn[1] ? int'(y) : (dig_sdn[2] ? 2 * int'(y) : 0);
        if (dig_sdn[0]) pp = -pp;
        acc += pp * (4 ** int'(dig_idx));
      end
      @(posedge clk); #1;
      if (rdy) k++;
    end
    dig_ready = 1'b0;
    checks++;
    if (k != n) begin
      failures++;
      $display("FAIL stream_len x=%02h got=%0d want=%0d", x, k, n);
    end
    checks++;
    if (dig_valid !== 1'b0 || in_ready !== 1'b1 || dig_sdn !== 3'b000 || dig_idx !== 2'd0 || dig_last !== 1'b0) begin
      failures++;
      $display("FAIL back_to_idle x=%02h got valid=%b ready=%b sdn=%b idx=%0d last=%b want 0 1 000 0 0",
               x, dig_valid, in_ready, dig_sdn, dig_idx, dig_last);
    end
    expv = int'($signed(x)) * int'(y);
    checks++;
    if (acc != expv) begin
      failures++;
      $display("FAIL product x=%02h y=%0d got=%0d want=%0d", x, y, acc, expv);
    end
    if (stall_mode == 0) begin
      checks++;
      if (cycles != n) begin
        failures++;
        $display("FAIL throughput x=%02h got=%0d want=%0d", x, cycles, n);
      end
    end
    if (stall_mode == 2 && n > 1) begin
      checks++;
      if (stalls != 3) begin
        failures++;
        $display("FAIL stall_count x=%02h got=%0d want=3", x, stalls);
      end
    end
    $display("operand x=%02h y=%0d digits=%0d cycles=%0d product=%0d", x, y, k, cycles, acc);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (in_ready !== 1'b1 || dig_valid !== 1'b0 || dig_sdn !== 3'b000 || dig_idx !== 2'd0 || dig_last !== 1'b0) begin
      failures++;
      $display("FAIL %s got ready=%b valid=%b sdn=%b idx=%0d last=%b want 1 0 000 0 0",
               name, in_ready, dig_valid, dig_sdn, dig_idx, dig_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; dig_ready = 1'b1; in_x = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0; in_valid = 1'b0; dig_ready = 1'b0;
    $display("reset done");
  endtask

  task automatic test_directed();
    run_operand(8'h0B, 0, 8'sd7);
    run_operand(8'h80, 0, -8'sd3);
    run_operand(8'hFF, 0, 8'sd100);
    run_operand(8'h00, 0, 8'sd55);
  endtask

  task automatic test_backpressure();
    run_operand(8'h0B, 2, -8'sd9);
  endtask

  task automatic test_reset_midstream();
    int guard;
    in_x = 8'h0B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dig_ready = 1'b1;
    guard = 0;
    while (!(dig_valid && dig_idx == 2'd2) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL reach_idx2 got timeout want idx=2");
    end
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; dig_ready = 1'b0;
    check_idle_outputs("reset_midstream");
    $display("reset mid-stream done");
    run_operand(8'h05, 0, 8'sd13);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      run_operand(8'($urandom), 1, 8'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      run_operand(8'($urandom), 0, 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; dig_ready = 1'b0; in_x = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_digit_encoder.md
BOOTH_DIGIT_ENCODER -- requirements
Module: booth_digit_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the signed multiplier operand width; WIDTH is even and at least 4.
REQ-002 SHALL derive the digit count N = WIDTH/2 and the index width IW = clog2(N).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand.
REQ-007 SHALL have port in_x, input, WIDTH bits: multiplier operand, two's complement.
REQ-008 SHALL have port dig_valid, output, 1 bit: a digit is presented.
REQ-009 SHALL have port dig_ready, input, 1 bit: the downstream partial-product decoder takes the digit.
REQ-010 SHALL have port dig_sdn, output, 3 bits: signed digit {two, one, neg}; bit0 = neg, bit1 = select 1·y, bit2 = select 2·y.
REQ-011 SHALL have port dig_idx, output, IW bits: digit position i (weight 4^i).
REQ-012 SHALL have port dig_last, output, 1 bit: final digit of the current operand.

Function
REQ-013 SHALL implement state machine IDLE -> EMIT -> IDLE.
- in_ready = 1 exactly when the state is IDLE.
- dig_valid = 1 exactly when the state is EMIT.
REQ-014 SHALL, on in_valid & in_ready, latch in_x, set the digit pointer to 0 and enter EMIT; the first digit is valid the next cycle (latency 1).
REQ-015 SHALL encode digit i from triplet (x[2i+1], x[2i], x[2i-1]), with x[-1] = 0, into dig_sdn as follows:
- 000 and 111 -> 000
- 001 and 010 -> 010
- 011 -> 100
- 100 -> 101
- 101 and 110 -> 011
REQ-016 SHALL never emit a negative zero; the value-zero digit is always 000.
REQ-017 SHALL hold dig_sdn, dig_idx and dig_last stable while dig_valid = 1 and dig_ready = 0.
REQ-018 SHALL advance to the next emitted digit on dig_valid & dig_ready.
REQ-019 SHALL assert dig_last on the final digit of the operand; the handshake of that digit returns the block to IDLE.
REQ-020 SHALL not accept a new operand in the cycle of the last-digit handshake.
- in_ready rises the following cycle.
- Throughput is (emitted digits + 1) cycles per operand with dig_ready held at 1.
REQ-021 SHALL drive dig_sdn, dig_idx and dig_last to 0 whenever dig_valid = 0.
REQ-022 SHALL guarantee that sum over emitted digits of value(dig_sdn)·4^dig_idx equals signed in_x exactly.

Reset
REQ-023 SHALL, on any rising edge with rst = 1, enter IDLE from any state and discard any latched operand or partially emitted digit stream.
REQ-024 SHALL ignore in_valid and dig_ready while rst = 1.
REQ-025 SHALL present, after the reset edge, in_ready = 1, dig_valid = 0, dig_sdn = 000, dig_idx = 0 and dig_last = 0.

Configuration
REQ-026 SHALL, with macro BOOTH_ZERO_SKIP_EN undefined, emit all N digits in order idx 0..N-1 and assert dig_last only at idx N-1.
REQ-027 SHALL, with BOOTH_ZERO_SKIP_EN defined, suppress value-zero digits (000).
- dig_idx carries the true position of each emitted digit.
- dig_last marks the last nonzero digit: all higher bits x[WIDTH-1:2i+1] are equal.
- An operand whose digits are all zero emits exactly one digit: sdn = 000, idx = 0, last = 1.
- The zero-skip logic costs no added latency or bubble cycles.

Verification (WIDTH = 8)
REQ-028 SHALL cover in_x = 8'h0B with dig_ready = 1.
- Expect sdn 011, 011, 010, 000 at idx 0..3, with last at idx 3.
- With the macro defined: 011, 011, 010 at idx 0..2, with last at idx 2.
REQ-029 SHALL cover in_x = 8'h80 and 8'hFF.
- 8'h80 -> digits 000, 000, 000, 101; with the macro, a single digit 101 at idx 3 with last.
- 8'hFF -> digits 011, 000, 000, 000; with the macro, a single digit 011 at idx 0 with last.
REQ-030 SHALL cover in_x = 8'h00 -> four 000 digits; with the macro, one 000 digit at idx 0 with last.
REQ-031 SHALL cover backpressure: in_x = 8'h0B with dig_ready = 0 for 3 cycles at idx 1.
- dig_sdn holds 011 and dig_idx holds 1 throughout.
- in_ready stays 0; the stream resumes unchanged.
REQ-032 SHALL cover reset mid-stream: rst pulsed for 1 cycle while idx 2 is presented.
- The next cycle shows dig_valid = 0 and in_ready = 1.
- A new operand 8'h05 then yields 010, 010, 000, 000.
REQ-033 SHALL cover a cross-check: 200 random in_x and y values, each emitted digit decoded by the team's partial-product decoder and accumulated.
- The accumulated total equals in_x·y for every pair, with and without BOOTH_ZERO_SKIP_EN.
